cache_refill: RTL and testbench



---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_refill.sv | 173 +++++++++++++++++
 tb/tb_cache_refill.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Types and constants shared between the cache and its refill engine.
package cache_pkg;

  localparam int CACHE_ADDR_BITS  = 10;
  localparam int CACHE_BLOCK_BITS = 2;
  localparam int BLOCK_WORDS      = 2 ** CACHE_BLOCK_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [CACHE_ADDR_BITS-CACHE_BLOCK_BITS-1:0] base;
    logic [CACHE_BLOCK_BITS-1:0]                 offset;
  } block_addr_t;

endpackage

// File: rtl/cache_refill.sv
// Miss-service engine: critical-word-first block refill bursts and
// single-word write-through, one request at a time.
module cache_refill
  import cache_pkg::*;
#(
  parameter int RAM_ADDRESS_BITS = CACHE_ADDR_BITS,
  parameter int DATA_WIDTH       = 32,
  parameter int BLOCK_BITS       = CACHE_BLOCK_BITS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [RAM_ADDRESS_BITS-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]       req_write_data,
  input  logic                        req_write_en,
  output logic                        fill_valid,
  output logic [BLOCK_BITS-1:0]       fill_offset,
  output logic [DATA_WIDTH-1:0]       fill_data,
  output logic                        fill_last,
  output logic                        done,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [RAM_ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]       mem_write_data,
  output logic                        mem_write_en,
  input  logic                        mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]       mem_rsp_data,
  output logic                        error
);

  localparam int BASE_BITS = RAM_ADDRESS_BITS - BLOCK_BITS;
  localparam logic [BLOCK_BITS:0] WORDS     = {1'b1, {BLOCK_BITS{1'b0}}};
  localparam logic [BLOCK_BITS:0] LAST_BEAT = {1'b0, {BLOCK_BITS{1'b1}}};

  state_e                      state_q, state_d;
  logic [BASE_BITS-1:0]        base_q, base_d;
  logic [BLOCK_BITS-1:0]       start_q, start_d;
  logic [BLOCK_BITS:0]         issue_q, issue_d;
  logic [BLOCK_BITS:0]         rsp_q, rsp_d;
  logic                        mem_req_valid_q, mem_req_valid_d;
  logic [RAM_ADDRESS_BITS-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0]       mem_write_data_q, mem_write_data_d;
  logic                        mem_write_en_q, mem_write_en_d;
  logic                        fill_valid_q, fill_valid_d;
  logic [BLOCK_BITS-1:0]       fill_offset_q, fill_offset_d;
  logic [DATA_WIDTH-1:0]       fill_data_q, fill_data_d;
  logic                        fill_last_q, fill_last_d;
  logic                        done_q, done_d;
  logic                        error_q, error_d;
  logic                        cmd_fire;
  logic                        beat_ok;
  logic [BLOCK_BITS-1:0]       issue_off;

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    start_d          = start_q;
    issue_d          = issue_q;
    rsp_d            = rsp_q;
    mem_req_valid_d  = mem_req_valid_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_write_en_d   = mem_write_en_q;
    fill_valid_d     = 1'b0;
    fill_offset_d    = fill_offset_q;
    fill_data_d      = fill_data_q;
    fill_last_d      = 1'b0;
    done_d           = 1'b0;
    error_d          = error_q;
    cmd_fire         = mem_req_valid_q && mem_req_ready;
    issue_off        = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d           = req_address[RAM_ADDRESS_BITS-1:BLOCK_BITS];
          start_d          = req_address[BLOCK_BITS-1:0];
          issue_d          = '0;
          rsp_d            = '0;
          mem_req_valid_d  = 1'b1;
          mem_address_d    = req_address;
          mem_write_data_d = req_write_data;
          mem_write_en_d   = req_write_en;
          state_d          = req_write_en ? WRITE : READ;
        end
      end
      WRITE: begin
        if (cmd_fire) begin
          mem_req_valid_d = 1'b0;
          mem_write_en_d  = 1'b0;
          done_d          = 1'b1;
          state_d         = DONE;
        end
      end
      READ: begin
        // Next command address is computed from the post-accept count so
        // the address only moves once the current command is taken.
        if (cmd_fire) issue_d = issue_q + 1'b1;
        issue_off       = start_q + issue_d[BLOCK_BITS-1:0];
        mem_req_valid_d = (issue_d < WORDS);
        mem_address_d   = {base_q, issue_off};
        if (fill_last_q) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A response is only legal while a read is outstanding.
    beat_ok = mem_rsp_valid && (state_q == READ) && (rsp_q != issue_q);
    if (beat_ok) begin
      fill_valid_d  = 1'b1;
      fill_offset_d = start_q + rsp_q[BLOCK_BITS-1:0];
      fill_data_d   = mem_rsp_data;
      fill_last_d   = (rsp_q == LAST_BEAT);
      rsp_d         = rsp_q + 1'b1;
    end else if (mem_rsp_valid) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      base_q           <= '0;
      start_q          <= '0;
      issue_q          <= '0;
      rsp_q            <= '0;
      mem_req_valid_q  <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      mem_write_en_q   <= 1'b0;
      fill_valid_q     <= 1'b0;
      fill_offset_q    <= '0;
      fill_data_q      <= '0;
      fill_last_q      <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      base_q           <= base_d;
      start_q          <= start_d;
      issue_q          <= issue_d;
      rsp_q            <= rsp_d;
      mem_req_valid_q  <= mem_req_valid_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_write_en_q   <= mem_write_en_d;
      fill_valid_q     <= fill_valid_d;
      fill_offset_q    <= fill_offset_d;
      fill_data_q      <= fill_data_d;
      fill_last_q      <= fill_last_d;
      done_q           <= done_d;
      error_q          <= error_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign fill_valid     = fill_valid_q;
  assign fill_offset    = fill_offset_q;
  assign fill_data      = fill_data_q;
  assign fill_last      = fill_last_q;
  assign done           = done_q;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_write_en   = mem_write_en_q;
  assign error          = error_q;

endmodule

// File: tb/tb_cache_refill.sv
// Randomized bench for cache_refill against a RAM model and a burst-level
// expectation of commands, fill beats and done pulses.
module tb_cache_refill;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BB = 2;
  localparam int NW = 4;

  typedef struct {
    int             cyc;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic           we;
  } cmd_t;

  typedef struct {
    int             cyc;
    logic [BB-1:0]  off;
    logic [DW-1:0]  data;
    logic           last;
  } beat_t;

  typedef struct {
    int             due;
    logic [AW-1:0]  addr;
  } pend_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_address = '0;
  logic [DW-1:0] req_write_data = '0;
  logic          req_write_en = 1'b0;
  logic          fill_valid;
  logic [BB-1:0] fill_offset;
  logic [DW-1:0] fill_data;
  logic          fill_last;
  logic          done;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_en;
  logic          mem_rsp_valid = 1'b0;
  logic [DW-1:0] mem_rsp_data = '0;
  logic          error;

  always #5 clk = ~clk;

  cache_refill #(.RAM_ADDRESS_BITS(AW), .DATA_WIDTH(DW), .BLOCK_BITS(BB)) dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
    .req_write_data(req_write_data), .req_write_en(req_write_en),
    .fill_valid(fill_valid), .fill_offset(fill_offset), .fill_data(fill_data),
    .fill_last(fill_last), .done(done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .error(error)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ram_data(input logic [AW-1:0] a);
    return {{(DW-AW){1'b0}}, a};
  endfunction

  // RAM model controls, written only by the stimulus process
  int ready_rand = 0;
  int lat_min = 1;
  int lat_max = 1;
  int arm_cnt = 0;
  int spur_cnt = 0;

  // Observations, written only by the monitor
  int    cyc = 0;
  cmd_t  cmds[$];
  beat_t beats[$];
  int    dones[$];
  int    vcnt = 0;
  int    stab_err = 0;
  pend_t pend[$];
  int    arm_seen = 0;
  int    spur_seen = 0;
  int    low_left = 0;
  logic  hold_pend = 1'b0;
  cmd_t  hold_cmd;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b1;
      hold_pend = 1'b0;
      low_left = 0;
      arm_seen = arm_cnt;
      spur_seen = spur_cnt;
    end else begin
      if (fill_valid) beats.push_back('{cyc, fill_offset, fill_data, fill_last});
      if (done) dones.push_back(cyc);
      if (mem_req_valid) vcnt++;
      if (hold_pend && !(mem_req_valid && mem_address == hold_cmd.addr &&
          mem_write_en == hold_cmd.we && (!hold_cmd.we || mem_write_data == hold_cmd.data)))
        stab_err++;
      mem_rsp_valid = 1'b0;
      if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'h5151_0000;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data = ram_data(pend[0].addr);
        void'(pend.pop_front());
      end
      if (arm_cnt != arm_seen) begin
        arm_seen = arm_cnt;
        low_left = 3;
      end
      if (low_left > 0 && mem_req_valid) begin
        mem_req_ready = 1'b0;
        low_left--;
      end else if (ready_rand != 0) begin
        mem_req_ready = 1'($urandom_range(0, 1));
      end else begin
        mem_req_ready = 1'b1;
      end
      if (mem_req_valid && mem_req_ready) begin
        cmds.push_back('{cyc, mem_address, mem_write_data, mem_write_en});
        if (!mem_write_en)
          pend.push_back('{cyc + int'($urandom_range(lat_min, lat_max)), mem_address});
      end
      hold_pend = mem_req_valid && !mem_req_ready;
      hold_cmd = '{cyc, mem_address, mem_write_data, mem_write_en};
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic we, output int hs);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (!req_ready) check("req_ready_wait", 0, 1);
    req_valid = 1'b1;
    req_address = a;
    req_write_data = d;
    req_write_en = we;
    hs = cyc;
    tick();
    req_valid = 1'b0;
  endtask

  // One request end to end; exact adds the cycle-accurate expectations
  // for an always-ready, latency-1 RAM.
  task automatic run_txn(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic we, input bit exact);
    int hs, c0, b0, d0, s0, n;
    logic [AW-1:0] ea;
    logic [BB-1:0] eo;
    c0 = cmds.size(); b0 = beats.size(); d0 = dones.size(); s0 = stab_err;
    do_req(a, d, we, hs);
    n = 0;
    while (dones.size() == d0 && n < 300) begin tick(); n++; end
    check("done_seen", 64'(dones.size() > d0), 1);
    check("ready_in_done", req_ready, 0);
    tick();
    check("ready_after_done", req_ready, 1);
    repeat (4) tick();
    check("done_count", dones.size() - d0, 1);
    check("cmd_stable", stab_err - s0, 0);
    check("error_quiet", error, 0);
    if (we) begin
      check("wr_cmd_count", cmds.size() - c0, 1);
      check("wr_no_beats", beats.size() - b0, 0);
      if (cmds.size() > c0) begin
        check("wr_addr", cmds[c0].addr, a);
        check("wr_data", cmds[c0].data, d);
        check("wr_en", cmds[c0].we, 1);
        if (exact && dones.size() > d0) check("wr_done_cyc", dones[d0], cmds[c0].cyc + 1);
      end
    end else begin
      check("rd_cmd_count", cmds.size() - c0, NW);
      check("rd_beat_count", beats.size() - b0, NW);
      for (int i = 0; i < NW; i++) begin
        ea = (a & ~AW'(NW - 1)) | ((a + AW'(i)) & AW'(NW - 1));
        eo = BB'((a + AW'(i)) % NW);
        if (cmds.size() > c0 + i) begin
          check("rd_cmd_addr", cmds[c0+i].addr, ea);
          check("rd_cmd_we", cmds[c0+i].we, 0);
          if (exact) check("rd_cmd_cyc", cmds[c0+i].cyc, hs + 1 + i);
        end
        if (beats.size() > b0 + i) begin
          check("beat_off", beats[b0+i].off, eo);
          check("beat_data", beats[b0+i].data, ram_data(ea));
          check("beat_last", beats[b0+i].last, 64'(i == NW - 1));
          if (exact) check("beat_cyc", beats[b0+i].cyc, hs + 3 + i);
        end
      end
      if (exact && dones.size() > d0) check("rd_done_cyc", dones[d0], hs + 7);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_fill_valid"}, fill_valid, 0);
    check({tag, "_fill_last"}, fill_last, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_req_valid"}, mem_req_valid, 0);
    check({tag, "_mem_write_en"}, mem_write_en, 0);
    check({tag, "_mem_address"}, mem_address, 0);
    check({tag, "_error"}, error, 0);
  endtask

  initial begin
    int hs, c0, v0, d0, b0, n;
    logic [AW-1:0] ra;
    repeat (3) tick();
    check_reset_outputs("rst");
    check("rst_fill_data", fill_data, 0);
    rst = 1'b0;
    tick();

    // Critical word already at block start, then a wrapping start.
    run_txn(10'h01C, 32'h0, 1'b0, 1'b1);
    run_txn(10'h2A7, 32'h0, 1'b0, 1'b1);

    // Write-through with the RAM stalling three cycles.
    arm_cnt++;
    c0 = cmds.size(); v0 = vcnt; d0 = dones.size();
    run_txn(10'h055, 32'hDEAD_BEEF, 1'b1, 1'b1);
    check("wr_valid_cycles", vcnt - v0, 4);

    // Randomized ready and RAM latency.
    ready_rand = 1; lat_min = 1; lat_max = 5;
    for (int i = 0; i < 12; i++) begin
      ra = AW'($urandom);
      run_txn(ra, $urandom, 1'($urandom_range(0, 3) == 0), 1'b0);
    end
    ready_rand = 0; lat_min = 1; lat_max = 1;

    // Spurious response while idle.
    b0 = beats.size();
    spur_cnt++;
    tick(); tick();
    check("spur_error", error, 1);
    repeat (5) tick();
    check("spur_error_sticky", error, 1);
    check("spur_no_beats", beats.size() - b0, 0);
    rst = 1'b1;
    #1;
    check("spur_error_cleared", error, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset in the middle of a burst.
    b0 = beats.size();
    do_req(10'h130, 32'h0, 1'b0, hs);
    n = 0;
    while (beats.size() - b0 < 2 && n < 50) begin tick(); n++; end
    check("mid_two_beats", beats.size() - b0, 2);
    check("mid_valid_before", mem_req_valid, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    tick(); tick();
    rst = 1'b0;
    check("mid_ready_release", req_ready, 1);
    tick();
    run_txn(10'h3F1, 32'h0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
